ram_ctrl: RTL and testbench

- Two-port scheduler in front of the byte-wide data RAM.
- Arbitrates between an instruction-fetch requester (port 0) and a load/store requester (port 1), round-robin.
- Sequences byte, half and word accesses as 1/2/4 consecutive single-byte RAM cycles, little-endian.
- Checks length, alignment and range, and returns one response per accepted request.

---
 rtl/ram_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/ram_ctrl.sv | 146 ++++++++++++++
 tb/tb_ram_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types for the two-port RAM scheduler: size encodings, FSM states, byte counts.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ram_pkg;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  typedef enum logic [1:0] {IDLE, CHECK, XFER, DONE} state_t;

  // Number of RAM byte cycles for an access size; the illegal code maps to 1
  // but never reaches XFER because CHECK flags it.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_H:   return 3'd2;
      LEN_W:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter with a one-hot grant.
// Latency: combinational grant; priority pointer moves on the clock edge after a grant.
// Backpressure: a request simply stays pending until granted; update gates pointer movement.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // last_q = 1 means port 1 was granted last, so port 0 wins the next tie.
  logic last_q;

  // One-hot grant: a lone request wins, a tie goes to the port not granted last.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the winner only when a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (update && (|grant)) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/ram_ctrl.sv
// Two-port scheduler for a byte-wide RAM: round-robin grant, 1/2/4 byte cycles, LE, error checks.
// Latency: ack N+2 cycles after the request is seen in IDLE (2 on error); one request per N+3 cycles.
// Backpressure: requester holds valid until its ack pulse; the other port waits while a transfer runs.
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int RAM_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_valid,
  input  logic        p0_we,
  input  logic [1:0]  p0_len,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_valid,
  input  logic        p1_we,
  input  logic [1:0]  p1_len,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  state_t      state_q, state_d;
  logic        port_q;
  logic        we_q;
  logic [1:0]  len_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  k_q;
  logic        err_q;
  logic [1:0]  grant;
  logic        chk_err;
  logic        last_byte;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({p1_valid, p0_valid}),
    .update (state_q == IDLE),
    .grant  (grant)
  );

  // Exception check on the latched request: bad size, misalignment, or beyond the RAM.
  always_comb begin
    chk_err = (len_q == 2'b11)
           || ((len_q == LEN_H) && addr_q[0])
           || ((len_q == LEN_W) && (addr_q[1:0] != 2'b00))
           || ((addr_q >> RAM_WIDTH) != 32'd0);
    last_byte = ({1'b0, k_q} == (len_bytes(len_q) - 3'd1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus all outputs, decoded from registered state so strobes are glitch-free.
  always_comb begin
    state_d   = state_q;
    mem_rw    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 8'd0;
    p0_ack    = 1'b0;
    p0_rdata  = 32'd0;
    p0_err    = 1'b0;
    p1_ack    = 1'b0;
    p1_rdata  = 32'd0;
    p1_err    = 1'b0;
    case (state_q)
      IDLE:  if (|grant) state_d = CHECK;
      CHECK: state_d = chk_err ? DONE : XFER;
      XFER: begin
        mem_addr = addr_q + {30'd0, k_q};
        if (we_q) begin
          mem_rw    = 1'b1;
          mem_wdata = wdata_q[{k_q, 3'b000} +: 8];
        end
        if (last_byte) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (port_q) begin
          p1_ack   = 1'b1;
          p1_rdata = rdata_q;
          p1_err   = err_q;
        end else begin
          p0_ack   = 1'b1;
          p0_rdata = rdata_q;
          p0_err   = err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, error capture and little-endian read assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      len_q   <= LEN_B;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      k_q     <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            port_q  <= grant[1];
            we_q    <= grant[1] ? p1_we    : p0_we;
            len_q   <= grant[1] ? p1_len   : p0_len;
            addr_q  <= grant[1] ? p1_addr  : p0_addr;
            wdata_q <= grant[1] ? p1_wdata : p0_wdata;
            rdata_q <= 32'd0;
            k_q     <= 2'd0;
            err_q   <= 1'b0;
          end
        end
        CHECK: err_q <= chk_err;
        XFER: begin
          if (!we_q) rdata_q[{k_q, 3'b000} +: 8] <= mem_rdata;
          k_q <= k_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl with a behavioural byte RAM and an expected-response queue.
// Latency: responses are timed in cycles from the IDLE cycle that sees the request.
// Backpressure: requests are held until ack (or dropped early where the scenario asks for it).
module tb_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_valid, p0_we, p1_valid, p1_we;
  logic [1:0]  p0_len, p1_len;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_clr;
  logic [7:0]  mem [0:1023];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  ram_ctrl #(.RAM_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_len(p0_len), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_len(p1_len), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural byte RAM: combinational read, write on the clock edge.
  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (mem_rw) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int port, input logic we, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_valid = 1'b1; p0_we = we; p0_len = len; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_valid = 1'b1; p1_we = we; p1_len = len; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  // One request on one port; checks latency, data, error, write-strobe count and idle-port silence.
  task automatic run_req(input string tag, input int port, input logic we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                         input int exp_mw, input bit drop_early);
    exp_t e;
    int   cyc = 0;
    int   mw = 0;
    int   other = 0;
    bit   got = 0;
    e.port = port; e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    @(posedge clk); #1;
    drive(port, we, len, addr, wdata);
    while (cyc < 20 && !got) begin
      @(negedge clk);
      if (mem_rw) mw++;
      if ((port == 0) ? p1_ack : p0_ack) other++;
      if ((port == 0) ? p0_ack : p1_ack) begin
        got = 1;
        e = sb.pop_front();
        chk({tag, "_lat"},   cyc, e.lat);
        chk({tag, "_rdata"}, (port == 0) ? p0_rdata : p1_rdata, e.rdata);
        chk({tag, "_err"},   {31'd0, (port == 0) ? p0_err : p1_err}, {31'd0, e.err});
        p0_valid = 1'b0; p1_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
        if (drop_early && cyc == 0) begin
          p0_valid = 1'b0; p1_valid = 1'b0;
        end
        cyc++;
      end
    end
    if (!got) begin
      void'(sb.pop_front());
      p0_valid = 1'b0; p1_valid = 1'b0;
    end
    chk({tag, "_ack"},   {31'd0, got}, 32'd1);
    chk({tag, "_mw"},    mw, exp_mw);
    chk({tag, "_other"}, other, 0);
  endtask

  initial begin
    int   nack;
    int   cyc;
    int   acks;
    exp_t e;

    rst_n = 1'b0; mem_clr = 1'b1;
    p0_valid = 1'b0; p0_we = 1'b0; p0_len = 2'b00; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_len = 2'b00; p1_addr = '0; p1_wdata = '0;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_p0_ack",   {31'd0, p0_ack}, 32'd0);
    chk("rst_p1_ack",   {31'd0, p1_ack}, 32'd0);
    chk("rst_mem_rw",   {31'd0, mem_rw}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    chk("rst_p1_err",   {31'd0, p1_err}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Word write then read back on port 1.
    run_req("p1_wwr", 1, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 6, 4, 1'b0);
    chk("mem10", {24'd0, mem[16]}, 32'hEF);
    chk("mem11", {24'd0, mem[17]}, 32'hBE);
    chk("mem12", {24'd0, mem[18]}, 32'hAD);
    chk("mem13", {24'd0, mem[19]}, 32'hDE);
    run_req("p1_wrd", 1, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 6, 0, 1'b0);

    // Misaligned half, then byte write/read at the same odd address.
    run_req("p0_hmis", 0, 1'b0, 2'b01, 32'h11, 32'h0, 32'h0, 1'b1, 2, 0, 1'b0);
    run_req("p0_bwr",  0, 1'b1, 2'b00, 32'h11, 32'hFFFFFF5A, 32'h0, 1'b0, 3, 1, 1'b0);
    run_req("p0_brd",  0, 1'b0, 2'b00, 32'h11, 32'h0, 32'h5A, 1'b0, 3, 0, 1'b0);

    // Out of range and illegal size, both as writes so a stray strobe would show.
    run_req("p1_range", 1, 1'b1, 2'b10, 32'h400, 32'h12345678, 32'h0, 1'b1, 2, 0, 1'b0);
    run_req("p1_len3",  1, 1'b1, 2'b11, 32'h0,   32'h12345678, 32'h0, 1'b1, 2, 0, 1'b0);

    // Aligned half read: zero-extended upper bytes.
    run_req("p1_hrd", 1, 1'b0, 2'b01, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 4, 0, 1'b0);

    // Both ports request continuously; last grant was port 1, so order is 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      e.port = i % 2; e.rdata = (i % 2 == 0) ? 32'h5A : 32'hEF; e.err = 1'b0; e.lat = 3 + 4 * i;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, 32'h11, 32'h0);
    drive(1, 1'b0, 2'b00, 32'h10, 32'h0);
    nack = 0; cyc = 0;
    while (cyc < 40 && nack < 4) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        e = sb.pop_front();
        chk("arb_both_ack", {31'd0, p0_ack & p1_ack}, 32'd0);
        chk("arb_port",  {31'd0, p1_ack}, e.port);
        chk("arb_rdata", p1_ack ? p1_rdata : p0_rdata, e.rdata);
        chk("arb_lat",   cyc, e.lat);
        nack++;
        if (nack == 4) begin
          p0_valid = 1'b0; p1_valid = 1'b0;
        end
      end
      if (nack < 4) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("arb_nack", nack, 4);
    p0_valid = 1'b0; p1_valid = 1'b0;
    sb.delete();

    // Reset during the third XFER cycle of a word write: two bytes land, no ack.
    @(posedge clk); #1;
    drive(0, 1'b1, 2'b10, 32'h40, 32'h11223344);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0; p0_valid = 1'b0;
    #1;
    chk("ar_mem_rw",    {31'd0, mem_rw}, 32'd0);
    chk("ar_mem_addr",  mem_addr, 32'd0);
    chk("ar_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (p0_ack || p1_ack) acks++;
    end
    chk("ar_no_ack", acks, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("ar_mem40", {24'd0, mem[64]}, 32'h44);
    chk("ar_mem41", {24'd0, mem[65]}, 32'h33);
    chk("ar_mem42", {24'd0, mem[66]}, 32'h00);
    chk("ar_mem43", {24'd0, mem[67]}, 32'h00);
    run_req("p0_post_rst", 0, 1'b0, 2'b10, 32'h40, 32'h0, 32'h00003344, 1'b0, 6, 0, 1'b0);

    // Port 1 drops valid right after grant; upper write bytes are ignored.
    run_req("p1_drop", 1, 1'b1, 2'b01, 32'h20, 32'hFFFF1234, 32'h0, 1'b0, 4, 2, 1'b1);
    chk("drop_mem20", {24'd0, mem[32]}, 32'h34);
    chk("drop_mem21", {24'd0, mem[33]}, 32'h12);
    chk("drop_mem22", {24'd0, mem[34]}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
